// File: rtl/echo_sample_buffer.sv
// Echo sample buffer: captures ADC samples during an acquisition window
// into a show-ahead FIFO, with capture counting, overflow flag and an
// end-of-window pulse.
module echo_sample_buffer #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] ADC_DATA,
    input  logic                  FIFO_EN,
    input  logic                  CLR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [ADDR_WIDTH:0]   WORD_COUNT,
    output logic [ADDR_WIDTH:0]   CAPTURE_COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVERFLOW,
    output logic                  ECHO_DONE
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   cap_q, cap_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  full, empty, pop, wr_en, drop;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // CLR blocks both write and pop in its cycle; a full buffer still
    // accepts a sample when the head is popped in the same cycle.
    assign pop   = !empty && RD_READY && !CLR;
    assign wr_en = FIFO_EN && (!full || pop) && !CLR;
    assign drop  = FIFO_EN && full && !pop && !CLR;

    // State register and all datapath/status registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cap_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cap_q    <= cap_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Sample storage; contents are not reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= ADC_DATA;
        end
    end

    // Window FSM next state and end-of-window pulse
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (FIFO_EN) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!FIFO_EN) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, occupancy, capture count and overflow next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cap_d    = cap_q;
        ovf_d    = ovf_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (state_q == IDLE && FIFO_EN) begin
            cap_d = wr_en ? ONE_C : '0;
        end else if (state_q == CAPTURE && wr_en && cap_q != DEPTH_C) begin
            cap_d = cap_q + 1'b1;
        end

        if (drop) ovf_d = 1'b1;

        if (CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            cap_d    = '0;
            ovf_d    = 1'b0;
        end
    end

    assign RD_DATA       = mem[rd_ptr_q];
    assign RD_VALID      = !empty;
    assign WORD_COUNT    = count_q;
    assign CAPTURE_COUNT = cap_q;
    assign FULL          = full;
    assign EMPTY         = empty;
    assign OVERFLOW      = ovf_q;
    assign ECHO_DONE     = done_q;

endmodule
